// File: rtl/_demux16_stream_if.sv
// Handshake bundle for the 1-to-16 stream demux: one input port, 16 valid/ready
// output channels sharing a single data bus.
interface _demux16_stream_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_sel;
  logic [N-1:0] in_data;
  logic [15:0]  out_valid;
  logic [15:0]  out_ready;
  logic [N-1:0] out_data;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/_demux16_stream.sv
// Registered 1-to-16 demultiplexer: a one-entry buffer steers each word to the
// channel named by its index, with a wrapping count of delivered words.
module _demux16_stream #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  _demux16_stream_if.slave bus,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           full_q, full_d;
  logic [3:0]       sel_q, sel_d;
  logic [N-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;
  logic             accept;

  // Only the addressed channel's ready matters; the other 15 are ignored.
  assign drain        = (full_q == FULL) & bus.out_ready[sel_q];
  assign bus.in_ready = (full_q == EMPTY) | drain;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    full_d = full_q;
    sel_d  = sel_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (accept) begin
      full_d = FULL;
      sel_d  = bus.in_sel;
      data_d = bus.in_data;
    end else if (drain) begin
      full_d = EMPTY;
    end
    if (drain) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= EMPTY;
      sel_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_chan
    localparam logic [3:0] K = 4'(k);
    assign bus.out_valid[k] = (full_q == FULL) & (sel_q == K);
  end

  assign bus.out_data = data_q;
  assign xfer_cnt     = cnt_q;

endmodule

// File: tb/tb__demux16_stream.sv
// Directed bench for the 1-to-16 stream demux: reset, single word, stall,
// back-to-back, counter wrap (4-bit instance) and reset while stalled.
module tb__demux16_stream;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  _demux16_stream_if #(.N(N)) bus ();
  _demux16_stream_if #(.N(N)) bus_w ();
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt_w;

  _demux16_stream #(.N(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .xfer_cnt(xfer_cnt)
  );

  _demux16_stream #(.N(N), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w), .xfer_cnt(xfer_cnt_w)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] exp_cnt = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 4'd5;
    bus.in_data  = 32'h0000_0077;
    step();
    total_cnt++;
    if (bus.out_valid !== 16'h0000) $display("FAIL reset_out_valid got %h want 0000", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== 16'd0) $display("FAIL reset_xfer_cnt got %0d want 0", xfer_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", bus.out_data);
    else pass_cnt++;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    exp_cnt      = '0;
  endtask

  task automatic test_single();
    bus.out_ready = 16'hFFFF;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 4'd9;
    bus.in_data   = 32'h0000_00A5;
    step();
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 16'h0200) $display("FAIL single_out_valid got %h want 0200", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_data !== 32'hA5) $display("FAIL single_out_data got %h want 000000a5", bus.out_data);
    else pass_cnt++;
    step();
    exp_cnt++;
    total_cnt++;
    if (bus.out_valid !== 16'h0000) $display("FAIL single_drained got %h want 0000", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== exp_cnt) $display("FAIL single_cnt got %0d want %0d", xfer_cnt, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    bus.out_ready = 16'hFFF7;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 4'd3;
    bus.in_data   = 32'h0000_003C;
    step();
    // next word waits behind the stalled one
    bus.in_sel  = 4'd7;
    bus.in_data = 32'h0000_0099;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (bus.out_valid !== 16'h0008) $display("FAIL stall_out_valid[%0d] got %h want 0008", i, bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_data !== 32'h3C) $display("FAIL stall_out_data[%0d] got %h want 0000003c", i, bus.out_data);
      else pass_cnt++;
      total_cnt++;
      if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b want 0", i, bus.in_ready);
      else pass_cnt++;
      total_cnt++;
      if (xfer_cnt !== exp_cnt) $display("FAIL stall_cnt[%0d] got %0d want %0d", i, xfer_cnt, exp_cnt);
      else pass_cnt++;
      step();
    end
    bus.out_ready = 16'hFFFF;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL stall_release_in_ready got %b want 1", bus.in_ready);
    else pass_cnt++;
    step();
    exp_cnt++;
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 16'h0080) $display("FAIL reload_out_valid got %h want 0080", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_data !== 32'h99) $display("FAIL reload_out_data got %h want 00000099", bus.out_data);
    else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== exp_cnt) $display("FAIL reload_cnt got %0d want %0d", xfer_cnt, exp_cnt);
    else pass_cnt++;
    step();
    exp_cnt++;
    total_cnt++;
    if (xfer_cnt !== exp_cnt) $display("FAIL stall_final_cnt got %0d want %0d", xfer_cnt, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 16'hFFFF;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_sel  = 4'(i);
      bus.in_data = 32'h100 + 32'(i);
      step();
      if (i > 0) exp_cnt++;
      total_cnt++;
      if (bus.out_valid !== (16'h1 << i)) $display("FAIL b2b_out_valid[%0d] got %h want %h", i, bus.out_valid, 16'h1 << i);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_data !== 32'h100 + 32'(i)) $display("FAIL b2b_out_data[%0d] got %h want %h", i, bus.out_data, 32'h100 + 32'(i));
      else pass_cnt++;
      total_cnt++;
      if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got %b want 1", i, bus.in_ready);
      else pass_cnt++;
      total_cnt++;
      if (xfer_cnt !== exp_cnt) $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, xfer_cnt, exp_cnt);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    step();
    exp_cnt++;
    total_cnt++;
    if (bus.out_valid !== 16'h0000) $display("FAIL b2b_end_out_valid got %h want 0000", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== 16'd19) $display("FAIL b2b_end_cnt got %0d want 19", xfer_cnt);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bus_w.out_ready = 16'hFFFF;
    bus_w.in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus_w.in_sel  = 4'(i);
      bus_w.in_data = 32'(i);
      step();
    end
    total_cnt++;
    if (xfer_cnt_w !== 4'd0) $display("FAIL wrap_cnt_16 got %0d want 0", xfer_cnt_w);
    else pass_cnt++;
    bus_w.in_valid = 1'b0;
    step();
    total_cnt++;
    if (xfer_cnt_w !== 4'd1) $display("FAIL wrap_cnt_17 got %0d want 1", xfer_cnt_w);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 16'hEFFF;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 4'd12;
    bus.in_data   = 32'hDEAD_BEEF;
    step();
    total_cnt++;
    if (bus.out_valid !== 16'h1000) $display("FAIL rmid_pending got %h want 1000", bus.out_valid);
    else pass_cnt++;
    rst_n       = 1'b0;
    bus.in_sel  = 4'd2;
    bus.in_data = 32'h1234_5678;
    step();
    total_cnt++;
    if (bus.out_valid !== 16'h0000) $display("FAIL rmid_out_valid got %h want 0000", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (xfer_cnt !== 16'd0) $display("FAIL rmid_cnt got %0d want 0", xfer_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_data !== 32'h0) $display("FAIL rmid_out_data got %h want 0", bus.out_data);
    else pass_cnt++;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 16'hFFFF;
    step();
    total_cnt++;
    if (bus.out_valid !== 16'h0000 || xfer_cnt !== 16'd0)
      $display("FAIL rmid_after got out_valid=%h cnt=%0d want 0000 0", bus.out_valid, xfer_cnt);
    else pass_cnt++;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_sel      = '0;
    bus.in_data     = '0;
    bus.out_ready   = '0;
    bus_w.in_valid  = 1'b0;
    bus_w.in_sel    = '0;
    bus_w.in_data   = '0;
    bus_w.out_ready = '0;
    step();
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
